// File: rtl/farm_sensor_ctrl.sv
// farm_sensor_ctrl
// Conditions the raw farm-road loop detector for the trafficlights
// controller. The detector is synchronised, then debounced. The module keeps
// a saturating count of the vehicles queued on the farm road. The count rises
// on an accepted arrival while the farm lamp is not GREEN. It falls on an
// accepted departure while the farm lamp is GREEN. The car-waiting request
// x is high whenever the count is non-zero.
module farm_sensor_ctrl #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       farm,
  output logic             x,
  output logic [CNT_W-1:0] queue,
  output logic             overflow
);

  // The debounce counter only ever needs to reach DEBOUNCE-1.
  localparam int                DBC_W      = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBC_W-1:0]  DBC_LAST   = DBC_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  Q_MAX      = '1;
  localparam logic [1:0]        FARM_GREEN = 2'd2;

  // Two-stage synchroniser for the asynchronous detector input.
  logic             r_s1;
  logic             r_s2;

  // Debounce state: accepted level plus count of consecutive disagreeing cycles.
  logic             r_det;
  logic [DBC_W-1:0] r_dbc;

  // Vehicle queue and sticky saturation flag.
  logic [CNT_W-1:0] r_queue;
  logic             r_overflow;

  // Flip / event decode.
  logic             w_differ;
  logic             w_flip;
  logic             w_rise;
  logic             w_fall;
  logic             w_green;
  logic             w_arrive;
  logic             w_depart;
  logic             w_full;

  // The synchronised level must disagree with the accepted level on
  // DEBOUNCE consecutive edges. On the last of those edges it is accepted.
  assign w_differ = (r_s2 != r_det);
  assign w_flip   = w_differ && (r_dbc == DBC_LAST);
  assign w_rise   = w_flip && r_s2;
  assign w_fall   = w_flip && !r_s2;

  // The farm lamp is only looked at on the flip edge itself. Encoding 3
  // counts as not-GREEN.
  assign w_green  = (farm == FARM_GREEN);
  assign w_arrive = w_rise && !w_green;
  assign w_depart = w_fall && w_green && (r_queue != '0);
  assign w_full   = (r_queue == Q_MAX);

  // Synchroniser: nothing else in the block touches loop_raw.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= loop_raw;
      r_s2 <= r_s1;
    end
  end

  // Debounce: any agreeing cycle restarts the count. A pulse shorter than
  // DEBOUNCE cycles therefore never reaches the flip.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_det <= 1'b0;
      r_dbc <= '0;
    end else if (!w_differ) begin
      r_dbc <= '0;
    end else if (w_flip) begin
      r_det <= r_s2;
      r_dbc <= '0;
    end else begin
      r_dbc <= r_dbc + 1'b1;
    end
  end

  // Queue count. An arrival at full scale is dropped and recorded in the
  // sticky flag. A departure from an empty queue is ignored, so the count
  // cannot underflow.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_queue    <= '0;
      r_overflow <= 1'b0;
    end else if (w_arrive) begin
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_queue <= r_queue + 1'b1;
      end
    end else if (w_depart) begin
      r_queue <= r_queue - 1'b1;
    end
  end

  // The request is decoded straight from the queue register, so it cannot
  // glitch. It stays high through YELLOW and RED while vehicles remain.
  assign x        = (r_queue != '0);
  assign queue    = r_queue;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Bench for farm_sensor_ctrl.
// It drives two instances from the same stimulus: one with default
// parameters and one with a 2-bit queue.
module tb_farm_sensor_ctrl;

  localparam int          DEB   = 4;
  localparam logic [1:0]  RED   = 2'd0;
  localparam logic [1:0]  GREEN = 2'd2;

  logic       clk;
  logic       clear;
  logic       loop_raw;
  logic [1:0] farm;
  logic       x_a;
  logic [3:0] q_a;
  logic       ovf_a;
  logic       x_b;
  logic [1:0] q_b;
  logic       ovf_b;

  farm_sensor_ctrl dut_a (
    .clk      (clk),
    .clear    (clear),
    .loop_raw (loop_raw),
    .farm     (farm),
    .x        (x_a),
    .queue    (q_a),
    .overflow (ovf_a)
  );

  farm_sensor_ctrl #(.DEBOUNCE(DEB), .CNT_W(2)) dut_b (
    .clk      (clk),
    .clear    (clear),
    .loop_raw (loop_raw),
    .farm     (farm),
    .x        (x_b),
    .queue    (q_b),
    .overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         clr;
    bit         raw;
    logic [1:0] frm;
    int         qa;
    int         qb;
    bit         ovfb;
  } vec_t;

  vec_t tbl[$];

  // Reference model.
  // hist[0] is the most recent raw sample and hist[k] is the sample from
  // k edges earlier. The accepted level becomes v once the synchronised
  // samples seen on the last DEB edges have all been v.
  bit hist[$];
  bit m_det;
  int m_q[2];
  bit m_ovf[2];
  int m_max[2] = '{15, 3};

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
    m_det = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_q[c]   = 0;
      m_ovf[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit v;
    bit all_v;
    if (clear) begin
      model_reset();
    end else begin
      v     = !m_det;
      all_v = 1'b1;
      for (int i = 1; i <= DEB; i++) if (hist[i] != v) all_v = 1'b0;
      if (all_v) begin
        m_det = v;
        for (int c = 0; c < 2; c++) begin
          if (v && farm != GREEN) begin
            if (m_q[c] == m_max[c]) m_ovf[c] = 1'b1;
            else m_q[c] = m_q[c] + 1;
          end else if (!v && farm == GREEN && m_q[c] != 0) begin
            m_q[c] = m_q[c] - 1;
          end
        end
      end
      hist.push_front(loop_raw);
      void'(hist.pop_back());
    end
  endtask

  task automatic chk(input string nm, input int row, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", nm, row, act, exp);
    end
  endtask

  // One clock: drive the inputs after the falling edge and step the model
  // on the rising edge. Control returns at the next falling edge, which is
  // when the outputs are sampled.
  task automatic apply(input bit clr, input bit raw, input logic [1:0] frm);
    clear    = clr;
    loop_raw = raw;
    farm     = frm;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Appends n rows. Rows before index flip_at carry the "before" expectations.
  // Rows from flip_at onward carry the "after" expectations.
  task automatic add_run(input int n, input bit clr, input bit raw, input logic [1:0] frm,
                         input int flip_at,
                         input int qa0, input int qb0, input bit ov0,
                         input int qa1, input int qb1, input bit ov1);
    vec_t r;
    for (int i = 0; i < n; i++) begin
      r.clr = clr;
      r.raw = raw;
      r.frm = frm;
      if (i < flip_at) begin
        r.qa = qa0; r.qb = qb0; r.ovfb = ov0;
      end else begin
        r.qa = qa1; r.qb = qb1; r.ovfb = ov1;
      end
      tbl.push_back(r);
    end
  endtask

  initial begin
    int hold;
    bit raw;
    bit clr;
    logic [1:0] frm;

    clear    = 1'b1;
    loop_raw = 1'b0;
    farm     = RED;
    model_reset();

    // Reset: clear held while loop_raw toggles.
    for (int i = 0; i < 5; i++) add_run(1, 1'b1, bit'(i % 2), RED, 0, 0, 0, 0, 0, 0, 0);
    // Single car under RED. The flip lands on the 6th sampled edge. The
    // falling flip under RED leaves the queue alone.
    add_run(10, 1'b0, 1'b1, RED, 5, 0, 0, 0, 1, 1, 0);
    add_run(8,  1'b0, 1'b0, RED, 8, 1, 1, 0, 1, 1, 0);
    add_run(1,  1'b1, 1'b0, RED, 0, 0, 0, 0, 0, 0, 0);
    // Glitch rejection: 3-cycle pulses never flip.
    for (int k = 0; k < 4; k++) begin
      add_run(3, 1'b0, 1'b1, RED, 3, 0, 0, 0, 0, 0, 0);
      add_run(3, 1'b0, 1'b0, RED, 3, 0, 0, 0, 0, 0, 0);
    end
    add_run(4, 1'b0, 1'b0, RED, 4, 0, 0, 0, 0, 0, 0);
    // Service: three arrivals under RED, then three departures under GREEN.
    for (int k = 1; k <= 3; k++) begin
      add_run(6, 1'b0, 1'b1, RED, 5, k - 1, k - 1, 0, k, k, 0);
      add_run(6, 1'b0, 1'b0, RED, 6, k, k, 0, k, k, 0);
    end
    for (int k = 1; k <= 3; k++) begin
      add_run(6, 1'b0, 1'b1, GREEN, 6, 4 - k, 4 - k, 0, 4 - k, 4 - k, 0);
      add_run(6, 1'b0, 1'b0, GREEN, 5, 4 - k, 4 - k, 0, 3 - k, 3 - k, 0);
    end
    // A further pulse under GREEN on an empty queue: no underflow.
    add_run(6, 1'b0, 1'b1, GREEN, 6, 0, 0, 0, 0, 0, 0);
    add_run(6, 1'b0, 1'b0, GREEN, 6, 0, 0, 0, 0, 0, 0);
    // Saturation: the 2-bit instance tops out at 3 and flags the 4th arrival.
    add_run(6, 1'b0, 1'b1, RED, 5, 0, 0, 0, 1, 1, 0);
    add_run(6, 1'b0, 1'b0, RED, 6, 1, 1, 0, 1, 1, 0);
    add_run(6, 1'b0, 1'b1, RED, 5, 1, 1, 0, 2, 2, 0);
    add_run(6, 1'b0, 1'b0, RED, 6, 2, 2, 0, 2, 2, 0);
    add_run(6, 1'b0, 1'b1, RED, 5, 2, 2, 0, 3, 3, 0);
    add_run(6, 1'b0, 1'b0, RED, 6, 3, 3, 0, 3, 3, 0);
    add_run(6, 1'b0, 1'b1, RED, 5, 3, 3, 0, 4, 3, 1);
    add_run(6, 1'b0, 1'b0, RED, 6, 4, 3, 1, 4, 3, 1);
    add_run(6, 1'b0, 1'b1, RED, 5, 4, 3, 1, 5, 3, 1);
    add_run(6, 1'b0, 1'b0, RED, 6, 5, 3, 1, 5, 3, 1);
    add_run(1, 1'b1, 1'b0, RED, 0, 0, 0, 0, 0, 0, 0);
    // Reset mid-debounce: the partial count is discarded, then the car is
    // counted once after the full latency.
    add_run(3,  1'b0, 1'b1, RED, 3, 0, 0, 0, 0, 0, 0);
    add_run(1,  1'b1, 1'b1, RED, 0, 0, 0, 0, 0, 0, 0);
    add_run(10, 1'b0, 1'b1, RED, 5, 0, 0, 0, 1, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      apply(tbl[i].clr, tbl[i].raw, tbl[i].frm);
      chk("tbl_queue_a",    i, int'(q_a),   tbl[i].qa);
      chk("tbl_x_a",        i, int'(x_a),   int'(tbl[i].qa != 0));
      chk("tbl_overflow_a", i, int'(ovf_a), 0);
      chk("tbl_queue_b",    i, int'(q_b),   tbl[i].qb);
      chk("tbl_x_b",        i, int'(x_b),   int'(tbl[i].qb != 0));
      chk("tbl_overflow_b", i, int'(ovf_b), int'(tbl[i].ovfb));
    end

    // Randomised traffic checked against the model.
    apply(1'b1, 1'b0, RED);
    raw  = 1'b0;
    frm  = RED;
    hold = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold == 0) begin
        raw  = ~raw;
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) frm = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 299) == 0);
      apply(clr, raw, frm);
      chk("rnd_queue_a",    t, int'(q_a),   m_q[0]);
      chk("rnd_x_a",        t, int'(x_a),   int'(m_q[0] != 0));
      chk("rnd_overflow_a", t, int'(ovf_a), int'(m_ovf[0]));
      chk("rnd_queue_b",    t, int'(q_b),   m_q[1]);
      chk("rnd_x_b",        t, int'(x_b),   int'(m_q[1] != 0));
      chk("rnd_overflow_b", t, int'(ovf_b), int'(m_ovf[1]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/farm_sensor_ctrl.md
# farm_sensor_ctrl

Upstream conditioning stage for the `trafficlights` controller. It takes the raw farm-road vehicle loop detector, synchronises and debounces it, and keeps a saturating count of vehicles queued at the farm road. It drives the controller's single-bit car-waiting input `x`, and it reads back the controller's `farm` lamp state so it knows when queued vehicles are being served.

## Interface

Parameters:
- `DEBOUNCE`, default 4: consecutive synchronised cycles a new detector level must hold before it is accepted. Legal range is 2 or more.
- `CNT_W`, default 4: width of the vehicle queue counter.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `clear`, input, 1: reset, synchronous, active-high.
- `loop_raw`, input, 1: raw asynchronous loop detector; 1 means a vehicle is over the loop.
- `farm`, input, 2: farm lamp state from `trafficlights`. Encoding is RED=2'd0, YELLOW=2'd1, GREEN=2'd2; 2'd3 is treated as not-GREEN.
- `x`, output, 1: vehicle-waiting request to `trafficlights`.
- `queue`, output, CNT_W: number of vehicles currently queued.
- `overflow`, output, 1: sticky flag, set when an arrival was lost to saturation.

## Operation

- **Synchronizer:** two flops, `loop_raw` → `s1` → `s2`. Nothing downstream uses `loop_raw` directly.
- **Debounce:**
  - Registers are `det` (accepted level) and `dbc` (counter).
  - On any edge where `s2 == det`: `dbc <= 0`.
  - On an edge where `s2 != det` and `dbc < DEBOUNCE-1`: `dbc <= dbc+1`.
  - On an edge where `s2 != det` and `dbc == DEBOUNCE-1`: `det <= s2` and `dbc <= 0`. This edge is the "flip".
  - A pulse on `s2` shorter than `DEBOUNCE` cycles never changes `det`.
- **Arrival:** a flip of `det` from 0 to 1 while `farm != GREEN` gives `queue <= queue+1`.
  - A rising flip while `farm == GREEN` is a pass-through and leaves `queue` unchanged.
- **Departure:** a flip of `det` from 1 to 0 while `farm == GREEN` and `queue != 0` gives `queue <= queue-1`.
  - A falling flip in any other case leaves `queue` unchanged. There is no underflow.
- **Simultaneous events:** an arrival and a departure cannot occur on the same edge, because one flip has one direction.
- **Farm sampling:** `farm` is sampled on the same edge as the flip.
- **Saturation:** when an arrival occurs with `queue == 2^CNT_W-1`, `queue` holds and `overflow <= 1`. `overflow` clears only on `clear`.
- **Request:** `x = (queue != 0)`, decoded combinationally from the `queue` register, so it is glitch-free.
  - `x` stays high through YELLOW and RED if vehicles remain queued, so the controller re-serves them.

## Timing

- **Reset:** on a `clear` edge, `s1`, `s2`, `det`, `dbc`, `queue` and `overflow` all become 0, so `x`=0.
  - While `clear` is high, `loop_raw` and `farm` are ignored.
- **Reset mid-operation:** a partial debounce count or the queued vehicles are discarded at the first `clear` edge. A vehicle still sitting on the loop when `clear` deasserts is counted again after the full debounce.
- **Arrival latency:** `loop_raw` high sampled into `s1` at edge 0 and held gives:
  - `s2` = 1 after edge 1;
  - the flip and `queue` increment at edge `DEBOUNCE`+1;
  - `x` high after edge `DEBOUNCE`+1 (5 cycles with the defaults).
- **Departure latency:** the same path, `DEBOUNCE`+1 edges from `loop_raw` low to the `queue` decrement.
  - `x` falls on the edge where `queue` reaches 0.
- **Vehicle dwell:** a vehicle must hold `loop_raw` for at least `DEBOUNCE` cycles to be counted, and the gap between vehicles must also be at least `DEBOUNCE` cycles.
- **Farm changes:** a change of `farm` takes effect on the flip edge only. No latching of past GREEN is performed.

## Test plan

- **Reset:** hold `clear`=1 for 5 negedges with `loop_raw` toggling → `queue`=0, `x`=0, `overflow`=0 throughout and on release.
- **Single car, `farm`=RED, `DEBOUNCE`=4:** `loop_raw` high for 10 cycles, then low → `x` rises after the 5th edge from the first sample; `queue`=1 and stays 1 after `loop_raw` falls.
- **Glitch rejection:** `loop_raw` high for 3 cycles, then low; repeat 4 times → `queue`=0, `x`=0 throughout.
- **Service:** 3 arrivals under RED (`queue`=3); then `farm`=GREEN and 3 pulses of 6 high / 6 low → `queue` 2, 1, 0 on the falling flips; `x` falls with the last decrement. A further pulse under GREEN leaves `queue`=0.
- **Saturation, `CNT_W`=2:** 5 arrivals under RED → `queue`=3, `overflow`=1 on the 4th arrival; `clear` → both 0.
- **Reset mid-debounce:** `loop_raw` goes high, `clear` pulses 1 cycle at edge 3, `loop_raw` is then held 10 cycles → `queue` increments exactly once, `DEBOUNCE`+1 edges after the synchroniser re-samples post-`clear`.
